display_scan_ctrl: RTL

Time-multiplexing scheduler for the 4-digit seven-segment display. It owns the digit scan sequence, inserts a blanking gap between digits to stop ghosting, and presents one byte at a time to an external `DisplayMaster` decoder. It accepts a new 32-bit display word from the core-side dump logic through a valid/ready handshake. The word is applied atomically at a frame boundary, so a partially updated value is never shown.

---
 rtl/display_scan_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
//------------------------------------------------------------------------------
// display_scan_ctrl: 4-digit seven-segment scan scheduler with per-digit blanking
// and a frame-atomic display-word load; DISPLAY_SCAN_DIM_EN adds duty dimming.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl #(
    parameter int PRESCALE_W   = 13,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic [7:0]  num,
    input  logic [6:0]  seg_mask,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [1:0]  dim,
`endif
    output logic [3:0]  ds_en,
    output logic [6:0]  ds_seg,
    output logic        frame_tick
);

    localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BCW-1:0]        BLANK_LAST = BCW'(BLANK_CYCLES - 1);
    localparam logic [PRESCALE_W-1:0] CNT_LAST   = '1;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // With no blanking the FSM lives in SHOW permanently, including after reset.
    localparam state_t RESET_ST = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    state_t                 state, state_nx;
    logic [1:0]             dig, dig_nx;
    logic [PRESCALE_W-1:0]  cnt, cnt_nx;
    logic [BCW-1:0]         bcnt, bcnt_nx;
    logic                   boundary;

    logic [31:0]            active;
    logic [31:0]            shadow;
    logic                   pending;
    logic                   pending_nx;
    logic                   xfer;
    logic                   lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_ST;
            dig   <= 2'd0;
            cnt   <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            dig   <= dig_nx;
            cnt   <= cnt_nx;
            bcnt  <= bcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dig_nx   = dig;
        cnt_nx   = cnt;
        bcnt_nx  = bcnt;
        boundary = 1'b0;
        case (state)
            ST_BLANK: begin
                if (bcnt == BLANK_LAST) begin
                    bcnt_nx  = '0;
                    cnt_nx   = '0;
                    state_nx = ST_SHOW;
                end else begin
                    bcnt_nx = bcnt + 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    dig_nx   = dig + 2'd1;
                    boundary = (dig == 2'd3);
                    state_nx = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = RESET_ST;
        endcase
    end

    assign num  = active[{dig, 3'b000} +: 8];
    assign xfer = load_valid & load_ready;

    // A word is only accepted while nothing is pending, so pending and a new
    // transfer never coincide; a boundary transfer lands in shadow only.
    assign pending_nx = pending ? ~boundary : xfer;

`ifdef DISPLAY_SCAN_DIM_EN
    assign lit = (state == ST_SHOW) && (cnt[PRESCALE_W-1 -: 2] <= dim);
`else
    assign lit = (state == ST_SHOW);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 32'd0;
            shadow     <= 32'd0;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            ds_en      <= 4'hF;
            ds_seg     <= 7'd0;
            frame_tick <= 1'b0;
        end else begin
            if (xfer) begin
                shadow <= load_data;
            end
            if (boundary && pending) begin
                active <= shadow;
            end
            pending    <= pending_nx;
            load_ready <= ~pending_nx;
            ds_en      <= lit ? ~(4'b0001 << dig) : 4'hF;
            ds_seg     <= lit ? seg_mask : 7'd0;
            frame_tick <= boundary;
        end
    end

endmodule

`default_nettype wire
